// File: rtl/segled_mux_wb32.sv
// segled_mux_wb32: Wishbone32 slave driving a multiplexed 7-segment display of up to 8 digits
module segled_mux_wb32 #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLKDIV_W       = 12,
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic                  wb_ack_o,
    output logic [31:0]           wb_dat_o,
    output logic [NUM_DIGITS-1:0] segled_bsel,
    output logic [7:0]            segled_disp
);
    localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0] DMASK = 8'((9'd1 << NUM_DIGITS) - 9'd1);
    localparam logic [63:0] BMASK = 64'((65'd1 << (8 * NUM_DIGITS)) - 65'd1);
    localparam logic [NUM_DIGITS-1:0] SEL_INV = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
    localparam logic [7:0] SEG_INV = {8{SEG_ACTIVE_LOW != 0}};
    localparam logic [6:0] FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic [7:0]          en, pass, blink, frame, cur_byte, seg;
    logic [3:0]          bright, phase;
    logic [2:0]          blink_sel;
    logic [63:0]         data;
    logic [CLKDIV_W-1:0] div;
    logic [DW-1:0]       digit;
    logic [1:0]          adr;
    logic [31:0]         wmask, cur, wr;
    logic                req, tick, last, lit, unused_ok;

    assign adr       = wb_adr_i[3:2];
    assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wmask     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign tick      = div == '0;
    assign last      = digit == DW'(NUM_DIGITS - 1);
    assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0]};

    // Register readback word, byte-lane merged write word, and segment pattern for the scanned digit
    always_comb begin
        cur = adr == 2'd0 ? {8'h00, blink, pass, en} :
              adr == 2'd1 ? {25'h0, blink_sel, bright} :
              adr == 2'd2 ? data[31:0] : data[63:32];
        wr = (cur & ~wmask) | (wb_dat_i & wmask);
        cur_byte = data[{digit, 3'b000} +: 8];
        lit = phase != 4'd0 && phase != 4'd15 && phase <= bright;
        seg = (en[digit] && !(blink[digit] && frame[blink_sel]) && lit) ?
              (pass[digit] ? cur_byte : {cur_byte[7], FONT[cur_byte[3:0]]}) : 8'h00;
    end

    // Wishbone handshake: single-cycle ack, write or readback on the ack edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            en        <= '0;
            pass      <= '0;
            blink     <= '0;
            bright    <= '0;
            blink_sel <= '0;
            data      <= '0;
        end else begin
            wb_ack_o <= req;
            if (req && !wb_we_i) wb_dat_o <= cur;
            if (req && wb_we_i) begin
                if (adr == 2'd0) begin
                    en    <= wr[7:0] & DMASK;
                    pass  <= wr[15:8] & DMASK;
                    blink <= wr[23:16] & DMASK;
                end
                if (adr == 2'd1) begin
                    bright    <= wr[3:0];
                    blink_sel <= wr[6:4];
                end
                if (adr == 2'd2) data[31:0] <= wr & BMASK[31:0];
                if (adr == 2'd3) data[63:32] <= wr & BMASK[63:32];
            end
        end
    end

    // Scan timebase: prescaler, 16 phases per digit slot, digit walk and frame count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div   <= '0;
            phase <= '0;
            digit <= '0;
            frame <= '0;
        end else begin
            div <= div + 1'b1;
            if (tick) begin
                phase <= phase + 4'd1;
                if (phase == 4'd15) begin
                    digit <= last ? '0 : digit + 1'b1;
                    if (last) frame <= frame + 8'd1;
                end
            end
        end
    end

    // Output pins registered together so digit select and segments change on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segled_bsel <= SEL_INV;
            segled_disp <= SEG_INV;
        end else begin
            segled_bsel <= (NUM_DIGITS'(1) << digit) ^ SEL_INV;
            segled_disp <= seg ^ SEG_INV;
        end
    end
endmodule
